// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for the multiplier control
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HALT} mult_state_t;
endpackage

// File: rtl/mult_control_if.sv
// mult_control_if: button inputs, multiplier LSB and datapath control strobes of the multiplier
interface mult_control_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld;
  logic ClearAX;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;
  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done
  );
  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done
  );
endinterface

// File: rtl/mult_step_counter.sv
// mult_step_counter: counts add/shift step pairs and flags the last one
module mult_step_counter
  import mult_pkg::*;
#(
  parameter  int WIDTH = MULT_WIDTH,
  localparam int CW    = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over increment; otherwise the count holds
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // step count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign tc = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/mult_control.sv
// mult_control: sequences clear, add/shift step pairs and a final subtract for the signed multiplier
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic         Clk,
  input  logic         Reset_n,
  mult_control_if.slave bus
);
  mult_state_t state_q, state_d;
  logic tc;
  logic clr_ld, clear_ax, add, sub, shift, done;
  mult_step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (state_q == CLEAR),
    .inc   (state_q == SHIFT && !tc),
    .tc    (tc)
  );
  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  // next state and datapath strobes; the last step pair subtracts for the sign bit weight
  always_comb begin
    state_d  = IDLE;
    clr_ld   = 1'b0;
    clear_ax = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        clr_ld  = bus.ClearA_LoadB;
        state_d = (!bus.ClearA_LoadB && bus.Run) ? CLEAR : IDLE;
      end
      CLEAR: begin
        clear_ax = 1'b1;
        state_d  = ADD;
      end
      ADD: begin
        add     = bus.M && !tc;
        sub     = bus.M && tc;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift   = 1'b1;
        state_d = tc ? HALT : ADD;
      end
      HALT: begin
        done    = 1'b1;
        state_d = bus.Run ? HALT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.Clr_Ld  = Reset_n && clr_ld;
  assign bus.ClearAX = Reset_n && clear_ax;
  assign bus.Add     = Reset_n && add;
  assign bus.Sub     = Reset_n && sub;
  assign bus.Shift   = Reset_n && shift;
  assign bus.Busy    = Reset_n && (state_q == CLEAR || state_q == ADD || state_q == SHIFT);
  assign bus.Done    = Reset_n && done;
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: checks strobe timing against a cycle-indexed schedule and products against signed multiplication
module tb_mult_control;
  import mult_pkg::*;
  localparam int W = MULT_WIDTH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_drv = 1'b0;
  logic dp_mode = 1'b0;
  logic [7:0] sw = '0;
  logic [7:0] dp_a = '0;
  logic [7:0] dp_b = '0;
  logic dp_x = 1'b0;
  logic [7:0] b_model = '0;
  int n_cmp = 0;
  int n_bad = 0;
  mult_control_if bus();
  mult_control #(.WIDTH(W)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.M = dp_mode ? dp_b[0] : m_drv;
  // behavioural datapath: A/X accumulator, B multiplier, 9-bit adder
  always @(posedge clk) begin
    if (bus.Clr_Ld) begin
      dp_x <= 1'b0; dp_a <= '0; dp_b <= sw;
    end else if (bus.ClearAX) begin
      dp_x <= 1'b0; dp_a <= '0;
    end else if (bus.Add) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} + {sw[7], sw};
    end else if (bus.Sub) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} - {sw[7], sw};
    end else if (bus.Shift) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end
  // {Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done}
  function automatic logic [6:0] outs();
    return {bus.Clr_Ld, bus.ClearAX, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};
  endfunction
  // expected strobes in cycle c of an operation whose Run was sampled at edge 0
  function automatic logic [6:0] expect_op(input int c, input logic m);
    if (c == 1) return 7'b0100010;
    if (c >= 2 && c <= 2*W + 1) begin
      if (c % 2 == 0) return {2'b00, m && (c < 2*W), m && (c == 2*W), 1'b0, 1'b1, 1'b0};
      return 7'b0000110;
    end
    if (c >= 2*W + 2) return 7'b0000001;
    return 7'b0000000;
  endfunction
  task automatic run_op(input int hold, input int m_mode, input bit tog, input string name);
    int last, adds, subs, shifts;
    logic [6:0] exp;
    last = hold > 2*W + 2 ? hold : 2*W + 2;
    adds = 0; subs = 0; shifts = 0;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      bus.Run = c < hold;
      bus.ClearA_LoadB = (tog && c >= 1 && c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_drv = m_mode == 2 ? 1'($urandom_range(0, 1)) : m_mode[0];
      #1;
      exp = (c >= 1 && c <= last) ? expect_op(c, m_drv) : 7'b0;
      n_cmp++;
      if (outs() !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c, outs(), exp);
      end
      adds += int'(bus.Add);
      subs += int'(bus.Sub);
      shifts += int'(bus.Shift);
    end
    n_cmp++;
    if (shifts != W) begin
      n_bad++;
      $display("FAIL %s shift_count: got %0d want %0d", name, shifts, W);
    end
    if (m_mode == 1) begin
      n_cmp++;
      if (adds != W - 1 || subs != 1) begin
        n_bad++;
        $display("FAIL %s add_sub_count: got %0d/%0d want %0d/1", name, adds, subs, W - 1);
      end
    end
    if (m_mode == 0) begin
      n_cmp++;
      if (adds + subs != 0) begin
        n_bad++;
        $display("FAIL %s add_sub_count: got %0d want 0", name, adds + subs);
      end
    end
  endtask
  task automatic check_zero(input string name);
    n_cmp++;
    if (outs() !== 7'b0) begin
      n_bad++;
      $display("FAIL %s: got %b want 0000000", name, outs());
    end
  endtask
  task automatic test_reset();
    bus.Run = 1'b1; bus.ClearA_LoadB = 1'b1; m_drv = 1'b1;
    @(negedge clk); #1;
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1; bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0; m_drv = 1'b0;
    #1;
    check_zero("reset_release");
  endtask
  task automatic test_priority();
    @(negedge clk);
    bus.Run = 1'b1; bus.ClearA_LoadB = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== 7'b1000000) begin
      n_bad++;
      $display("FAIL priority_clr_ld: got %b want 1000000", outs());
    end
    @(negedge clk);
    bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0;
    #1;
    check_zero("priority_stays_idle");
    run_op(1, 0, 1'b0, "priority_run_alone");
  endtask
  task automatic test_reset_mid();
    logic [6:0] exp;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      bus.Run = c == 0; bus.ClearA_LoadB = 1'b0; m_drv = 1'b1;
      #1;
      exp = c == 0 ? 7'b0 : expect_op(c, 1'b1);
      n_cmp++;
      if (outs() !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_pre cycle %0d: got %b want %b", c, outs(), exp);
      end
    end
    @(negedge clk);
    bus.ClearA_LoadB = 1'b1; rst_n = 1'b0;
    #1;
    check_zero("reset_mid_assert");
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset_mid_hold");
    @(negedge clk);
    rst_n = 1'b1; bus.ClearA_LoadB = 1'b0;
    #1;
    check_zero("reset_mid_release");
    run_op(1, 1, 1'b0, "reset_mid_restart");
  endtask
  task automatic dp_load(input logic [7:0] b);
    @(negedge clk);
    sw = b; bus.ClearA_LoadB = 1'b1; bus.Run = 1'b0;
    @(negedge clk);
    bus.ClearA_LoadB = 1'b0;
    #1;
    b_model = b;
    n_cmp++;
    if (dp_b !== b) begin
      n_bad++;
      $display("FAIL dp_load: got %h want %h", dp_b, b);
    end
  endtask
  task automatic dp_run(input logic [7:0] s, input string name);
    logic signed [15:0] p;
    p = $signed({{8{s[7]}}, s}) * $signed({{8{b_model[7]}}, b_model});
    for (int c = 0; c <= 2*W + 3; c++) begin
      @(negedge clk);
      sw = s; bus.Run = c == 0; bus.ClearA_LoadB = 1'b0;
    end
    #1;
    n_cmp++;
    if ({dp_x, dp_a, dp_b} !== {p[15], p}) begin
      n_bad++;
      $display("FAIL %s product: got %b:%h:%h want %b:%h", name, dp_x, dp_a, dp_b, p[15], p);
    end
    b_model = p[7:0];
  endtask
  initial begin
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    test_reset();
    run_op(1, 1, 1'b0, "m1_run_pulse");
    run_op(30, 0, 1'b0, "m0_run_held");
    test_priority();
    run_op(22, 2, 1'b1, "clr_ignored_busy");
    test_reset_mid();
    dp_mode = 1'b1;
    dp_load(8'h07);
    dp_run(8'hFE, "dp_7_x_m2");
    dp_run(8'h03, "dp_reuse_b");
    for (int i = 0; i < 4; i++) begin
      dp_load(8'($urandom));
      dp_run(8'($urandom), "dp_random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Control FSM for the 8-bit signed shift-add multiplier datapath: A/X accumulator register, B multiplier register, 9-bit adder.
- Sequences the operation as one clear step, then WIDTH add/shift step pairs. The final step subtracts, so the result is two's-complement correct.
- Sits between the debounced/synchronised push-button inputs and the datapath register enables. Only this block decides when registers load, shift or clear.

Parameters:
- WIDTH, 8, operand width; sets the number of add/shift step pairs.

Ports:
- Clk  in  1  system clock; the block uses one clock only.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- Run  in  1  start request, level; already synchronised and debounced.
- ClearA_LoadB  in  1  clear A/X and load B from switches, level; already synchronised.
- M  in  1  current multiplier LSB (B[0]) from the datapath.
- Clr_Ld  out  1  datapath: clear A and X, load B with S.
- ClearAX  out  1  datapath: clear A and X only; B is kept.
- Add  out  1  datapath: load A/X with A + S (sign-extended 9-bit).
- Sub  out  1  datapath: load A/X with A - S (sign-extended 9-bit).
- Shift  out  1  datapath: arithmetic right shift of X:A:B.
- Busy  out  1  high in CLEAR, ADD and SHIFT.
- Done  out  1  high in HALT.

Behaviour:
- States (shared enum): IDLE, CLEAR, ADD, SHIFT, HALT. Step counter cnt has width $clog2(WIDTH).
- Reset_n low, at any time including mid-operation: state goes to IDLE and cnt to 0 asynchronously. All outputs are 0 while reset is held.
- IDLE:
  - ClearA_LoadB=1 gives Clr_Ld=1 in that cycle (combinational decode); state stays IDLE.
  - Else Run=1 moves to CLEAR.
  - ClearA_LoadB has priority when both are high in the same cycle; Run is ignored that cycle.
- CLEAR:
  - ClearAX=1 for exactly one cycle; cnt <= 0; next state is ADD.
  - This lets repeated Run presses multiply a new S by the previous B without reloading B.
- ADD:
  - If M=1 and cnt<WIDTH-1: Add=1.
  - If M=1 and cnt==WIDTH-1: Sub=1.
  - If M=0: no load.
  - Next state is SHIFT unconditionally.
  - Add and Sub are Mealy outputs on M and are never high together.
- SHIFT:
  - Shift=1.
  - If cnt==WIDTH-1: next state HALT; cnt holds.
  - Else cnt <= cnt+1; next state ADD.
- HALT:
  - Done=1.
  - Run=1 keeps the state in HALT, so a held button never restarts the operation.
  - Run=0 moves to IDLE.
  - ClearA_LoadB is ignored in HALT.
- Inputs ignored while busy: ClearA_LoadB and Run have no effect in CLEAR, ADD or SHIFT. The operation always completes unless Reset_n asserts.
- Latency, with Run sampled high in IDLE at edge 0:
  - CLEAR in cycle 1.
  - ADD in cycles 2+2k and SHIFT in cycles 3+2k, for k=0..WIDTH-1.
  - HALT from cycle 2*WIDTH+2, which is cycle 18 for WIDTH=8.
- At most one of Clr_Ld, ClearAX, Add, Sub, Shift is high in any cycle (one-hot-or-zero).
- Unreachable state encodings recover to IDLE on the next edge.

Decomposition:
- Package mult_pkg holds:
  - the state enum mult_state_t (IDLE, CLEAR, ADD, SHIFT, HALT);
  - the default constant MULT_WIDTH = 8.
- One sub-module, mult_step_counter:
  - clear, increment and terminal-count (cnt==WIDTH-1) outputs;
  - async active-low reset.
- The FSM register and output decode stay in mult_control.

Test Plan:
- Reset mid-operation: pulse Reset_n low in cycle 9 of an operation -> all outputs 0 immediately; state IDLE; Busy=0 after release; next Run starts a fresh sequence with CLEAR.
- M tied 1, Run pulsed high 1 cycle:
  - ClearAX in cycle 1;
  - Add in cycles 2,4,...,14 (7 pulses);
  - Sub in cycle 16 only;
  - Shift in cycles 3,5,...,17 (8 pulses);
  - Done from cycle 18.
- M tied 0, Run held high for 30 cycles -> zero Add/Sub pulses; 8 Shift pulses; state stays in HALT with Done=1 until Run drops; IDLE one cycle after release.
- ClearA_LoadB and Run both high in IDLE for 1 cycle -> Clr_Ld=1; state stays IDLE, Busy=0. Then Run alone -> CLEAR next cycle.
- ClearA_LoadB toggled during ADD/SHIFT and HALT -> Clr_Ld stays 0; sequence timing unchanged.
- Full datapath integration: B=0x07, S=0xFE (-2) -> X:A:B = 1:0xFF:0xF2 (-14); then Run again with S=0x03 and B unreloaded -> product of 0xF2 and 0x03 = 0xFFD6 (-42).
